// File: rtl/multicycle_ctrl_if.sv
// Controller <-> datapath bundle for the multi-cycle sequencer.
// master = sequencer (drives pc and strobes), slave = datapath / stimulus side.
interface multicycle_ctrl_if #(
  parameter int CNT_W = 16
);
  logic             start;
  logic [31:0]      ins;
  logic             zero;
  logic [31:0]      imm;
  logic [31:0]      jTarget;
  logic [31:0]      pc;
  logic             RegWrite;
  logic             ALUSrc;
  logic             MemRead;
  logic             MemWrite;
  logic             Mem2Reg;
  logic [2:0]       op;
  logic             busy;
  logic             illegal;
  logic [CNT_W-1:0] retired;

  modport master (
    input  start, ins, zero, imm, jTarget,
    output pc, RegWrite, ALUSrc, MemRead, MemWrite, Mem2Reg, op, busy, illegal, retired
  );

  modport slave (
    output start, ins, zero, imm, jTarget,
    input  pc, RegWrite, ALUSrc, MemRead, MemWrite, Mem2Reg, op, busy, illegal, retired
  );
endinterface

// File: rtl/multicycle_ctrl.sv
// Multi-cycle sequencer: owns pc and IR, walks FETCH..WB, decodes datapath strobes from state + IR.
// Strobes are combinational from registered state; pc/retired advance on the edge leaving an instruction.
module multicycle_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_0028,
  parameter int          CNT_W    = 16
) (
  input  logic              clk,
  input  logic              reset,
  multicycle_ctrl_if.master bus
);
  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT
  } state_e;

  typedef enum logic [2:0] {
    C_RTYPE, C_IALU, C_LOAD, C_STORE, C_BRANCH, C_JAL, C_BAD
  } cls_e;

  localparam logic [6:0] OPC_R    = 7'h33;
  localparam logic [6:0] OPC_IALU = 7'h13;
  localparam logic [6:0] OPC_LOAD = 7'h03;
  localparam logic [6:0] OPC_STOR = 7'h23;
  localparam logic [6:0] OPC_BEQ  = 7'h63;
  localparam logic [6:0] OPC_JAL  = 7'h6f;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;

  state_e           state_q, state_d;
  logic [31:0]      pc_q, pc_d;
  logic [31:0]      ir_q, ir_d;
  logic [CNT_W-1:0] retired_q, retired_d;
  logic             illegal_q, illegal_d;

  cls_e             cls;
  logic [2:0]       rtype_op;
  logic             retire;

  logic             reg_write;
  logic             alu_src;
  logic             mem_read;
  logic             mem_write;
  logic             mem2reg;
  logic [2:0]       alu_op;

  always_comb begin
    cls      = C_BAD;
    rtype_op = ALU_ADD;
    case (ir_q[6:0])
      OPC_R: begin
        cls = C_RTYPE;
        case (ir_q[14:12])
          3'b000:  rtype_op = ir_q[30] ? ALU_SUB : ALU_ADD;
          3'b110:  rtype_op = ALU_OR;
          3'b111:  rtype_op = ALU_AND;
          default: cls = C_BAD;
        endcase
      end
      OPC_IALU: cls = C_IALU;
      OPC_LOAD: cls = C_LOAD;
      OPC_STOR: cls = C_STORE;
      OPC_BEQ:  cls = C_BRANCH;
      OPC_JAL:  cls = C_JAL;
      default:  cls = C_BAD;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    ir_d      = ir_q;
    retired_d = retired_q;
    illegal_d = illegal_q;
    retire    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          state_d = S_FETCH;
        end
      end
      S_FETCH: begin
        ir_d    = bus.ins;
        state_d = S_DECODE;
      end
      S_DECODE: begin
        if (cls == C_BAD) begin
          illegal_d = 1'b1;
          state_d   = S_HALT;
        end else begin
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        case (cls)
          C_LOAD, C_STORE: state_d = S_MEM;
          C_BRANCH:        retire  = 1'b1;
          default:         state_d = S_WB;
        endcase
      end
      S_MEM: begin
        if (cls == C_LOAD) begin
          state_d = S_WB;
        end else begin
          retire = 1'b1;
        end
      end
      S_WB:    retire  = 1'b1;
      S_HALT:  state_d = S_HALT;
      default: state_d = S_IDLE;
    endcase

    // Leaving the last state of an instruction: advance pc, count it, refetch.
    if (retire) begin
      state_d   = S_FETCH;
      retired_d = retired_q + CNT_W'(1);
      if (cls == C_BRANCH && bus.zero) begin
        pc_d = pc_q + (bus.imm << 2);
      end else if (cls == C_JAL) begin
        pc_d = pc_q + (bus.jTarget << 2);
      end else begin
        pc_d = pc_q + 32'd4;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      pc_q      <= RESET_PC;
      ir_q      <= '0;
      retired_q <= '0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      ir_q      <= ir_d;
      retired_q <= retired_d;
      illegal_q <= illegal_d;
    end
  end

  // Strobes are masked by reset so nothing fires in the cycle reset is applied.
  always_comb begin
    reg_write = 1'b0;
    alu_src   = 1'b0;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    mem2reg   = 1'b0;
    alu_op    = ALU_ADD;
    if (!reset) begin
      case (state_q)
        S_EXEC: begin
          case (cls)
            C_RTYPE:  alu_op  = rtype_op;
            C_BRANCH: alu_op  = ALU_SUB;
            C_IALU, C_LOAD, C_STORE, C_JAL: alu_src = 1'b1;
            default:  alu_op  = ALU_ADD;
          endcase
        end
        S_MEM: begin
          mem_read  = (cls == C_LOAD);
          mem_write = (cls == C_STORE);
        end
        S_WB: begin
          reg_write = 1'b1;
          mem_read  = (cls == C_LOAD);
          mem2reg   = (cls == C_LOAD);
        end
        default: alu_op = ALU_ADD;
      endcase
    end
  end

  assign bus.pc       = pc_q;
  assign bus.RegWrite = reg_write;
  assign bus.ALUSrc   = alu_src;
  assign bus.MemRead  = mem_read;
  assign bus.MemWrite = mem_write;
  assign bus.Mem2Reg  = mem2reg;
  assign bus.op       = alu_op;
  assign bus.busy     = (state_q != S_IDLE) && (state_q != S_HALT);
  assign bus.illegal  = illegal_q;
  assign bus.retired  = retired_q;
endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: per-cycle expected control vectors go through a scoreboard queue.
module tb_multicycle_ctrl;
  typedef enum int {K_R, K_I, K_LD, K_ST, K_BEQ, K_JAL, K_BAD} kind_e;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  multicycle_ctrl_if #(.CNT_W(16)) bif ();

  multicycle_ctrl #(
    .RESET_PC (32'h0000_0028),
    .CNT_W    (16)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bif)
  );

  string       sb_tag[$];
  logic [57:0] sb_vec[$];
  int          n_cmp = 0;
  int          n_bad = 0;

  logic [31:0] m_pc;
  logic [15:0] m_ret;
  logic        m_ill;

  function automatic logic [57:0] pack(input logic [31:0] pc, input logic rw, input logic a_src,
                                       input logic mr, input logic mw, input logic m2r,
                                       input logic [2:0] op, input logic busy, input logic ill,
                                       input logic [15:0] ret);
    return {pc, rw, a_src, mr, mw, m2r, op, busy, ill, ret};
  endfunction

  function automatic logic [57:0] observe();
    return pack(bif.pc, bif.RegWrite, bif.ALUSrc, bif.MemRead, bif.MemWrite, bif.Mem2Reg,
                bif.op, bif.busy, bif.illegal, bif.retired);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input string tag, input logic [57:0] vec);
    sb_tag.push_back(tag);
    sb_vec.push_back(vec);
  endtask

  task automatic check_out();
    string       tag;
    logic [57:0] exp_v;
    logic [57:0] obs_v;
    #1;
    assert (sb_vec.size() != 0) else begin
      n_bad++;
      $error("FAIL scoreboard: observed empty queue expected an entry");
      return;
    end
    tag   = sb_tag.pop_front();
    exp_v = sb_vec.pop_front();
    obs_v = observe();
    n_cmp++;
    assert (obs_v === exp_v) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs_v, exp_v);
    end
  endtask

  task automatic expect_model(input string tag, input logic busy);
    push(tag, pack(m_pc, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'b010, busy, m_ill, m_ret));
    check_out();
  endtask

  task automatic reset_seq(input string tag);
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    m_pc  = 32'h0000_0028;
    m_ret = '0;
    m_ill = 1'b0;
    expect_model(tag, 1'b0);
  endtask

  task automatic start_pulse();
    bif.start = 1'b1;
    step();
    bif.start = 1'b0;
  endtask

  // Walks one instruction from FETCH; abort_at >= 0 applies reset in that cycle.
  task automatic run_instr(input string tag, input logic [31:0] word, input kind_e k,
                           input logic [2:0] rop, input logic z, input logic [31:0] im,
                           input logic [31:0] jt, input int abort_at);
    int n;
    case (k)
      K_LD:    n = 5;
      K_BEQ:   n = 3;
      K_BAD:   n = 2;
      default: n = 4;
    endcase
    bif.zero    = z;
    bif.imm     = im;
    bif.jTarget = jt;
    for (int c = 0; c < n; c++) begin
      logic       rw, a_src, mr, mw, m2r;
      logic [2:0] op;
      rw = 1'b0; a_src = 1'b0; mr = 1'b0; mw = 1'b0; m2r = 1'b0; op = 3'b010;
      bif.ins = (c == 0) ? word : $urandom();
      if (c == 2) begin
        case (k)
          K_R:                   op    = rop;
          K_BEQ:                 op    = 3'b110;
          K_I, K_LD, K_ST, K_JAL: a_src = 1'b1;
          default: ;
        endcase
      end
      if (c == 3) begin
        case (k)
          K_LD:            mr = 1'b1;
          K_ST:            mw = 1'b1;
          K_R, K_I, K_JAL: rw = 1'b1;
          default: ;
        endcase
      end
      if (c == 4 && k == K_LD) begin
        rw = 1'b1; mr = 1'b1; m2r = 1'b1;
      end
      if (c == abort_at) begin
        reset = 1'b1;
        push($sformatf("%s_rst", tag),
             pack(m_pc, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'b010, 1'b1, m_ill, m_ret));
        check_out();
        step();
        reset = 1'b0;
        m_pc  = 32'h0000_0028;
        m_ret = '0;
        m_ill = 1'b0;
        expect_model($sformatf("%s_idle", tag), 1'b0);
        return;
      end
      push($sformatf("%s_c%0d", tag, c), pack(m_pc, rw, a_src, mr, mw, m2r, op, 1'b1, m_ill, m_ret));
      check_out();
      step();
    end
    if (k == K_BAD) begin
      m_ill = 1'b1;
    end else begin
      if (k == K_BEQ && z) m_pc = m_pc + (im << 2);
      else if (k == K_JAL) m_pc = m_pc + (jt << 2);
      else m_pc = m_pc + 32'd4;
      m_ret = m_ret + 16'd1;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed no finish expected finish before 100us");
    $fatal(1);
  end

  initial begin
    reset       = 1'b1;
    bif.start   = 1'b0;
    bif.ins     = '0;
    bif.zero    = 1'b0;
    bif.imm     = '0;
    bif.jTarget = '0;
    m_pc  = 32'h0000_0028;
    m_ret = '0;
    m_ill = 1'b0;

    // Reset, idle hold, then R-type / load / store in sequence.
    reset_seq("reset");
    step();
    expect_model("idle_hold", 1'b0);
    start_pulse();
    run_instr("add", 32'h002081B3, K_R,  3'b010, 1'b0, 32'h40, 32'h10, -1);
    run_instr("lw",  32'h0000A183, K_LD, 3'b010, 1'b0, 32'h40, 32'h10, -1);
    run_instr("sw",  32'h0030A223, K_ST, 3'b010, 1'b0, 32'h40, 32'h10, -1);
    expect_model("after_sw", 1'b1);

    // OR / AND then beq not taken at 0x30.
    reset_seq("reset_b");
    start_pulse();
    run_instr("or",   32'h0020E1B3, K_R,   3'b001, 1'b0, 32'h40,       32'h10, -1);
    run_instr("and",  32'h0020F1B3, K_R,   3'b000, 1'b0, 32'h40,       32'h10, -1);
    run_instr("beq0", 32'h00208063, K_BEQ, 3'b010, 1'b0, 32'h00000003, 32'h10, -1);
    expect_model("after_beq0", 1'b1);

    // SUB, beq taken, jal wrapping backwards, illegal opcode into HALT.
    reset_seq("reset_c");
    start_pulse();
    run_instr("sub",   32'h402081B3, K_R,   3'b110, 1'b0, 32'h40,       32'h10,       -1);
    run_instr("addi1", 32'h00108093, K_I,   3'b010, 1'b0, 32'h40,       32'h10,       -1);
    run_instr("beq1",  32'h00208063, K_BEQ, 3'b010, 1'b1, 32'h00000003, 32'h10,       -1);
    run_instr("addi2", 32'h00108093, K_I,   3'b010, 1'b1, 32'h40,       32'h10,       -1);
    run_instr("jal",   32'h0000006F, K_JAL, 3'b010, 1'b0, 32'h40,       32'hFFFFFFFE, -1);
    run_instr("bad",   32'h0000007F, K_BAD, 3'b010, 1'b0, 32'h40,       32'h10,       -1);
    bif.start = 1'b1;
    for (int i = 0; i < 3; i++) begin
      expect_model($sformatf("halt%0d", i), 1'b0);
      step();
    end
    bif.start = 1'b0;

    // Reset landing in a store's MEM cycle.
    reset_seq("reset_d");
    start_pulse();
    run_instr("addi3", 32'h00108093, K_I,  3'b010, 1'b0, 32'h40, 32'h10, -1);
    run_instr("sw_rst", 32'h0030A223, K_ST, 3'b010, 1'b0, 32'h40, 32'h10, 3);
    step();
    expect_model("idle_after_rst", 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
